// File: rtl/digit_scan_pkg.sv
// Shared definitions for the display digit scanner: digit count, FSM state
// encoding and a one-hot helper used by the select register.
package digit_scan_pkg;

  localparam int NDIG = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  function automatic logic [NDIG-1:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/digit_scan_next_en_digit.sv
// Combinational enabled-digit picker. With from_lowest_i set it returns the
// lowest set bit of the mask; otherwise it returns the next set bit strictly
// after cur_i, searching cyclically (3 wraps to 0) and landing on cur_i itself
// only when it is the sole enabled digit.
module next_en_digit
  import digit_scan_pkg::*;
(
  input  logic [NDIG-1:0] mask_i,
  input  logic [1:0]      cur_i,
  input  logic            from_lowest_i,
  output logic [1:0]      nxt_o,
  output logic            valid_o
);

  logic [1:0] cand;

  // Priority search; later loop iterations win, so iterate from the lowest
  // priority candidate towards the highest.
  always_comb begin
    nxt_o   = cur_i;
    valid_o = |mask_i;
    cand    = cur_i;
    if (from_lowest_i) begin
      for (int i = NDIG - 1; i >= 0; i--) begin
        if (mask_i[i]) nxt_o = 2'(i);
      end
    end else begin
      for (int k = NDIG; k >= 1; k--) begin
        cand = cur_i + 2'(k);
        if (mask_i[cand]) nxt_o = cand;
      end
    end
  end

endmodule

// File: rtl/digit_scan.sv
// Display digit scanner: walks the enabled digits 0..3 cyclically, holding each
// for ON_CYCLES and inserting BLANK_CYCLES of all-zero select between digits.
// All outputs are registered and computed from the next-state values.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NDIG-1:0] digit_en,
  output logic [NDIG-1:0] sel,
  output logic [1:0]      digit_idx,
  output logic            frame_start,
  output logic            active
);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  // BLANK is never entered when the gap is zero, so the fallback value is unused.
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam bit               NO_GAP     = (BLANK_CYCLES == 0);

  scan_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [NDIG-1:0] sel_q, sel_d;
  logic            frame_q, frame_d;
  logic            active_q, active_d;
  logic            enter_on;
  logic [1:0]      pick_idx;
  logic            any_en;

  // One picker serves both the initial pick out of IDLE and the cyclic
  // advance (which also re-resolves a digit disabled during BLANK).
  next_en_digit u_pick (
    .mask_i        (digit_en),
    .cur_i         (idx_q),
    .from_lowest_i (state_q == ST_IDLE),
    .nxt_o         (pick_idx),
    .valid_o       (any_en)
  );

  // Next state, dwell counter and next output values; aborts override expiry.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_W'(1);
    enter_on = 1'b0;
    if (!en || !any_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          idx_d = pick_idx;
          cnt_d = '0;
          if (NO_GAP) begin
            state_d  = ST_ON;
            enter_on = 1'b1;
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d  = ST_ON;
            cnt_d    = '0;
            enter_on = 1'b1;
            idx_d    = digit_en[idx_q] ? idx_q : pick_idx;
          end
        end
        ST_ON: begin
          // A digit disabled mid-ON ends its period as if it had expired.
          if (cnt_q == ON_LAST || !digit_en[idx_q]) begin
            idx_d = pick_idx;
            cnt_d = '0;
            if (NO_GAP) begin
              state_d  = ST_ON;
              enter_on = 1'b1;
            end else begin
              state_d = ST_BLANK;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    sel_d    = (state_d == ST_ON) ? onehot(idx_d) : '0;
    // Frame starts when no enabled digit sits below the one being entered.
    frame_d  = enter_on && ((digit_en & (onehot(idx_d) - 4'd1)) == 4'd0);
    active_d = (state_d != ST_IDLE);
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      sel_q    <= '0;
      frame_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      frame_q  <= frame_d;
      active_q <= active_d;
    end
  end

  assign sel         = sel_q;
  assign digit_idx   = idx_q;
  assign frame_start = frame_q;
  assign active      = active_q;

endmodule

// File: tb/tb_digit_scan.sv
// Directed bench for digit_scan: one instance with ON=4/BLANK=2 and one with
// ON=1/BLANK=0, sharing clock, reset and inputs. Inputs change and outputs are
// sampled on the falling edge.
module tb_digit_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] digit_en = 4'b0000;

  logic [3:0] sel_a, sel_b;
  logic [1:0] idx_a, idx_b;
  logic       fs_a, fs_b;
  logic       act_a, act_b;

  int n_checks = 0;
  int n_fail   = 0;

  digit_scan #(.ON_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digit_en    (digit_en),
    .sel         (sel_a),
    .digit_idx   (idx_a),
    .frame_start (fs_a),
    .active      (act_a)
  );

  digit_scan #(.ON_CYCLES(1), .BLANK_CYCLES(0), .CNT_W(16)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digit_en    (digit_en),
    .sel         (sel_b),
    .digit_idx   (idx_b),
    .frame_start (fs_b),
    .active      (act_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int p, d;
    logic [3:0] exp_sel;
    logic [3:0] tbl4 [17:26];

    // Reset state
    repeat (2) step();
    check("rst_sel", sel_a, 4'b0000);
    check("rst_idx", idx_a, 2'd0);
    check("rst_fs", fs_a, 1'b0);
    check("rst_act", act_a, 1'b0);
    rst_n = 1'b1;
    step();
    check("idle_act", act_a, 1'b0);
    $display("reset phase done");

    // All four digits, ON=4 BLANK=2: 6-cycle digit period, 24-cycle frame
    digit_en = 4'b1111;
    en = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      p = (c - 1) % 6;
      d = ((c - 1) / 6) % 4;
      exp_sel = (p < 2) ? 4'b0000 : (4'b0001 << d);
      check("t1_sel", sel_a, exp_sel);
      check("t1_fs", fs_a, (p == 2 && d == 0));
      check("t1_act", act_a, 1'b1);
      if (p >= 2) check("t1_idx", idx_a, d);
    end
    $display("scan of mask 1111 done");
    en = 1'b0;
    step();
    check("t1_off_sel", sel_a, 4'b0000);
    check("t1_off_act", act_a, 1'b0);

    // Zero gap, ON=1: select rotates every cycle
    en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      check("t3_sel", sel_b, 4'b0001 << ((c - 1) % 4));
      check("t3_fs", fs_b, ((c - 1) % 4) == 0);
      check("t3_idx", idx_b, (c - 1) % 4);
    end
    $display("zero-gap rotation done");
    en = 1'b0;
    step();

    // Clear digit 2 during its second ON cycle
    en = 1'b1;
    for (int c = 1; c <= 16; c++) step();
    check("t4_pre_sel", sel_a, 4'b0100);
    digit_en = 4'b1011;
    tbl4[17] = 4'b0000; tbl4[18] = 4'b0000;
    tbl4[19] = 4'b1000; tbl4[20] = 4'b1000; tbl4[21] = 4'b1000; tbl4[22] = 4'b1000;
    tbl4[23] = 4'b0000; tbl4[24] = 4'b0000;
    tbl4[25] = 4'b0001; tbl4[26] = 4'b0001;
    for (int c = 17; c <= 26; c++) begin
      step();
      check("t4_sel", sel_a, tbl4[c]);
      check("t4_fs", fs_a, c == 25);
      if (c == 19) check("t4_idx", idx_a, 2'd3);
    end
    $display("mid-ON digit disable done");
    en = 1'b0;
    step();

    // Mask 1010: digits 1 and 3 alternate, frame on each entry to digit 1
    digit_en = 4'b1010;
    en = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      p = (c - 1) % 6;
      d = (((c - 1) / 6) % 2) ? 3 : 1;
      exp_sel = (p < 2) ? 4'b0000 : (4'b0001 << d);
      check("t2_sel", sel_a, exp_sel);
      check("t2_fs", fs_a, (p == 2 && d == 1));
      if (p >= 2) check("t2_idx", idx_a, d);
    end
    $display("scan of mask 1010 done");

    // en dropped mid-ON at digit 1, then re-raised
    en = 1'b0;
    step();
    check("t5_sel", sel_a, 4'b0000);
    check("t5_act", act_a, 1'b0);
    check("t5_idx", idx_a, 2'd1);
    en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t5_re_sel", sel_a, (c == 3) ? 4'b0010 : 4'b0000);
      check("t5_re_act", act_a, 1'b1);
      check("t5_re_fs", fs_a, c == 3);
    end
    $display("enable drop and restart done");

    // Asynchronous reset mid-ON, between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("t6_sel", sel_a, 4'b0000);
    check("t6_act", act_a, 1'b0);
    check("t6_fs", fs_a, 1'b0);
    step();
    check("t6_idx", idx_a, 2'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t6_post_sel", sel_a, (c == 3) ? 4'b0010 : 4'b0000);
      check("t6_post_act", act_a, 1'b1);
    end
    check("t6_post_idx", idx_a, 2'd1);
    $display("asynchronous reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
